fpu_dispatch: RTL and testbench

In-order operand dispatch stage that sits directly upstream of the operand demux in the floating-point co-processor. It buffers operand commands in a small FIFO, tracks which functional units are busy, and issues one command at a time to a free unit. Each issue drives a registered `op1`/`op2`/`select` triple plus a one-cycle `issue` strobe into the demux.

---
 rtl/fpu_dispatch.sv | 118 +++++++++++
 tb/tb_fpu_dispatch.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_dispatch.sv
// In-order FP operand dispatch: command FIFO, per-unit busy tracking, one issue per cycle.
// Optional FPU_DISPATCH_BYPASS_EN forwards unit_done straight into the free check.
module fpu_dispatch #(
  parameter int NUM_UNITS = 6,
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_unit,
  input  logic [31:0]          cmd_op1,
  input  logic [31:0]          cmd_op2,
  input  logic [TAG_W-1:0]     cmd_tag,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [31:0]          op1,
  output logic [31:0]          op2,
  output logic [2:0]           select,
  output logic                 issue,
  output logic [TAG_W-1:0]     issue_tag,
  output logic [NUM_UNITS-1:0] busy,
  output logic                 error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [2:0]       unit;
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

  cmd_t                 mem [DEPTH];
  cmd_t                 head;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  state_t               state_q, state_d;
  logic                 accept, legal, push, pop, head_free;
  logic [NUM_UNITS-1:0] avail, head_onehot, busy_d;

  assign cmd_ready = (count != CNT_W'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = ({1'b0, cmd_unit} < 4'(NUM_UNITS));
  assign push      = accept && legal;
  assign head      = mem[rd_ptr];

`ifdef FPU_DISPATCH_BYPASS_EN
  assign avail = ~busy | unit_done;
`else
  assign avail = ~busy;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_onehot = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      head_onehot[u] = (head.unit == 3'(u));
    end
  end

  assign head_free = |(head_onehot & avail);
  assign pop       = (count != '0) && head_free;

  // ISSUE marks the cycle right after a pop edge, so issue is a pure state decode.
  always_comb begin
    state_d = IDLE;
    if (pop)               state_d = ISSUE;
    else if (count != '0)  state_d = WAIT;
  end

  assign issue = (state_q == ISSUE);

  // Completion clears first; an issue to the same unit on the same edge re-sets the bit.
  always_comb begin
    busy_d = busy & ~unit_done;
    if (pop) busy_d = busy_d | head_onehot;
  end

  // NOTE: the command storage is left unreset; count gates every read, so stale entries are never used.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{unit: cmd_unit, op1: cmd_op1, op2: cmd_op2, tag: cmd_tag};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      op1       <= '0;
      op2       <= '0;
      select    <= '0;
      issue_tag <= '0;
      busy      <= '0;
      error     <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      count   <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        op1       <= head.op1;
        op2       <= head.op2;
        select    <= head.unit;
        issue_tag <= head.tag;
      end
      if (accept && !legal) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: directed scenarios plus random traffic,
// all compared against a queue-based reference model every cycle.
module tb_fpu_dispatch;

  localparam int NUM_UNITS = 6;
  localparam int DEPTH     = 4;
  localparam int TAG_W     = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_unit;
  logic [31:0]          cmd_op1, cmd_op2;
  logic [TAG_W-1:0]     cmd_tag;
  logic [NUM_UNITS-1:0] unit_done;
  logic [31:0]          op1, op2;
  logic [2:0]           select;
  logic                 issue;
  logic [TAG_W-1:0]     issue_tag;
  logic [NUM_UNITS-1:0] busy;
  logic                 error;

  always #5 clk = ~clk;

  fpu_dispatch #(.NUM_UNITS(NUM_UNITS), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_unit(cmd_unit),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_tag(cmd_tag),
    .unit_done(unit_done),
    .op1(op1), .op2(op2), .select(select), .issue(issue),
    .issue_tag(issue_tag), .busy(busy), .error(error)
  );

  typedef struct {
    int               unit;
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [TAG_W-1:0] tag;
  } mcmd_t;

  mcmd_t                mq[$];
  bit [NUM_UNITS-1:0]   m_busy;
  bit                   m_issue, m_error;
  logic [31:0]          m_op1, m_op2;
  int                   m_select;
  logic [TAG_W-1:0]     m_tag;
  int                   n_checks = 0;
  int                   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy   = '0;
    m_issue  = 1'b0;
    m_error  = 1'b0;
    m_op1    = '0;
    m_op2    = '0;
    m_select = 0;
    m_tag    = '0;
  endtask

  // One clock edge of the dispatch rules, applied to the inputs present at that edge.
  task automatic model_edge();
    bit    ready, go;
    mcmd_t h;
    if (rst) begin
      model_reset();
      return;
    end
    ready = (mq.size() < DEPTH);
    go    = 1'b0;
    if (mq.size() > 0) begin
      h  = mq[0];
      go = !m_busy[h.unit];
`ifdef FPU_DISPATCH_BYPASS_EN
      if (unit_done[h.unit]) go = 1'b1;
`endif
    end
    for (int u = 0; u < NUM_UNITS; u++) if (unit_done[u]) m_busy[u] = 1'b0;
    m_issue = go;
    if (go) begin
      void'(mq.pop_front());
      m_op1          = h.op1;
      m_op2          = h.op2;
      m_select       = h.unit;
      m_tag          = h.tag;
      m_busy[h.unit] = 1'b1;
    end
    if (cmd_valid && ready) begin
      if (int'(cmd_unit) >= NUM_UNITS) m_error = 1'b1;
      else mq.push_back('{int'(cmd_unit), cmd_op1, cmd_op2, cmd_tag});
    end
  endtask

  task automatic compare_all();
    check("cmd_ready", cmd_ready, mq.size() < DEPTH);
    check("issue", issue, m_issue);
    check("op1", op1, m_op1);
    check("op2", op2, m_op2);
    check("select", select, m_select);
    check("issue_tag", issue_tag, m_tag);
    check("busy", busy, m_busy);
    check("error", error, m_error);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input int unit, input logic [31:0] a,
                       input logic [31:0] b, input int tag);
    cmd_valid = v;
    cmd_unit  = 3'(unit);
    cmd_op1   = a;
    cmd_op2   = b;
    cmd_tag   = TAG_W'(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_issue", issue, 0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, gap, exp_gap;
    bit seen;

    rst = 1'b1;
    unit_done = '0;
    drive(0, 0, '0, '0, 0);
    #1;
    model_reset();
    compare_all();
    step();
    step();
    rst = 1'b0;

    // Single command: issue one cycle after acceptance.
    drive(1, 2, 32'h3F80_0000, 32'h4000_0000, 5);
    step();
    check("s1_no_early_issue", issue, 0);
    cmd_valid = 1'b0;
    step();
    check("s1_issue", issue, 1);
    check("s1_select", select, 2);
    check("s1_tag", issue_tag, 5);
    check("s1_op1", op1, 32'h3F80_0000);
    check("s1_busy", busy, 6'b000100);
    step();
    check("s1_strobe_one_cycle", issue, 0);
    unit_done = 6'b000100;
    step();
    unit_done = '0;

    // Two commands to unit 1; done arrives 3 cycles after the first issue.
    drive(1, 1, 32'h1, 32'h2, 1);
    step();
    drive(1, 1, 32'h3, 32'h4, 2);
    step();
    check("s2_first_issue", issue, 1);
    check("s2_first_tag", issue_tag, 1);
    cmd_valid = 1'b0;
    gap  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      unit_done = (k == 3) ? 6'b000010 : 6'b000000;
      step();
      if (issue === 1'b1) begin
        seen = 1'b1;
        gap  = k;
      end
    end
    unit_done = '0;
`ifdef FPU_DISPATCH_BYPASS_EN
    exp_gap = 3;
`else
    exp_gap = 4;
`endif
    check("s2_reissue_gap", gap, exp_gap);
    check("s2_second_tag", issue_tag, 2);
    unit_done = 6'b000010;
    step();
    unit_done = '0;

    // Fill the FIFO behind a busy unit 0.
    drive(1, 0, 32'hA, 32'hB, 0);
    step();
    cmd_valid = 1'b0;
    step();
    check("s3_busy0", busy[0], 1);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h100 + 32'(i), 32'h200 + 32'(i), i + 1);
      if (cmd_ready) acc++;
      step();
    end
    check("s3_accepted", acc, 4);
    check("s3_full", cmd_ready, 0);
    drive(1, 0, 32'h5555, 32'h6666, 5);
    step();
    unit_done = 6'b000001;
    step();
    unit_done = '0;
    check("s3_still_full", cmd_ready, 0);
    step();
    check("s3_pop_issue", issue, 1);
    check("s3_ready_after_pop", cmd_ready, 1);
    step();
    check("s3_fifth_taken", cmd_ready, 0);
    cmd_valid = 1'b0;

    // Reset with commands queued.
    do_reset();
    drive(1, 0, 32'h11, 32'h22, 1);
    step();
    for (int i = 2; i <= 4; i++) begin
      drive(1, 0, 32'h10 * 32'(i), 32'h20 * 32'(i), i);
      step();
    end
    cmd_valid = 1'b0;
    do_reset();
    check("s5_busy_clear", busy, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("s5_no_issue", issue, 0);
    end

    // Illegal unit index.
    drive(1, 7, 32'hDEAD, 32'hBEEF, 9);
    step();
    cmd_valid = 1'b0;
    step();
    check("s4_error", error, 1);
    check("s4_no_issue", issue, 0);
    step();
    step();
    step();
    check("s4_error_sticky", error, 1);
    do_reset();
    check("s4_error_cleared", error, 0);

    // Back-to-back issues to units 0, 1, 2.
    for (int u = 0; u < 3; u++) begin
      drive(1, u, 32'h1000 + 32'(u), 32'h2000 + 32'(u), u + 8);
      step();
      if (u > 0) begin
        check("s6_issue", issue, 1);
        check("s6_select", select, u - 1);
      end
    end
    cmd_valid = 1'b0;
    step();
    check("s6_issue_last", issue, 1);
    check("s6_select_last", select, 2);
    check("s6_busy", busy, 6'b000111);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_unit  = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, NUM_UNITS - 1));
      cmd_op1   = $urandom;
      cmd_op2   = $urandom;
      cmd_tag   = TAG_W'($urandom);
      unit_done = NUM_UNITS'($urandom & $urandom);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    unit_done = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
